// File: rtl/note_pkg.sv
// Shared definitions for the note tone player.
// Holds the scan codes of the seven note keys (Z X C V B N M -> DO..SI), the
// note frequencies in Hz, the player state enum, and helpers mapping a scan
// code to a note index and a note index to a tone half-period in clk cycles.
package note_pkg;

  localparam logic [7:0] KEY_DO = 8'h1A;
  localparam logic [7:0] KEY_RE = 8'h22;
  localparam logic [7:0] KEY_MI = 8'h21;
  localparam logic [7:0] KEY_FA = 8'h2A;
  localparam logic [7:0] KEY_SO = 8'h32;
  localparam logic [7:0] KEY_LA = 8'h31;
  localparam logic [7:0] KEY_SI = 8'h3A;

  localparam int unsigned FREQ_DO = 262;
  localparam int unsigned FREQ_RE = 294;
  localparam int unsigned FREQ_MI = 330;
  localparam int unsigned FREQ_FA = 349;
  localparam int unsigned FREQ_SO = 392;
  localparam int unsigned FREQ_LA = 440;
  localparam int unsigned FREQ_SI = 494;

  typedef enum logic [1:0] {
    StIdle,
    StPlay,
    StGap
  } state_t;

  // Returns 1..7 for a note key, 0 for any other code.
  function automatic logic [2:0] code_to_note(input logic [7:0] code);
    logic [2:0] idx;
    case (code)
      KEY_DO:  idx = 3'd1;
      KEY_RE:  idx = 3'd2;
      KEY_MI:  idx = 3'd3;
      KEY_FA:  idx = 3'd4;
      KEY_SO:  idx = 3'd5;
      KEY_LA:  idx = 3'd6;
      KEY_SI:  idx = 3'd7;
      default: idx = 3'd0;
    endcase
    return idx;
  endfunction

  // Half-period in clk cycles; only meant for elaboration-time use.
  // Index 0 (silence) gets 1 so the divider compare never underflows.
  function automatic logic [17:0] note_half_period(input logic [2:0] idx,
                                                   input int unsigned clk_hz);
    int unsigned freq;
    case (idx)
      3'd1:    freq = FREQ_DO;
      3'd2:    freq = FREQ_RE;
      3'd3:    freq = FREQ_MI;
      3'd4:    freq = FREQ_FA;
      3'd5:    freq = FREQ_SO;
      3'd6:    freq = FREQ_LA;
      3'd7:    freq = FREQ_SI;
      default: freq = 0;
    endcase
    if (freq == 0) return 18'd1;
    return 18'(clk_hz / (2 * freq));
  endfunction

endpackage

// File: rtl/tone_divider.sv
// Square-wave generator: toggles out every half_period enabled cycles.
// Ports:
//   clk, rst     clock and asynchronous active-high reset
//   en           advance the counter this cycle
//   half_period  cycles per half wave (must be >= 1)
//   clear        synchronous clear of counter and output; wins over en
//   out          square-wave output
module tone_divider (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [17:0] half_period,
  input  logic        clear,
  output logic        out
);

  logic [17:0] tone_cnt_q;
  logic        out_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tone_cnt_q <= '0;
      out_q      <= 1'b0;
    end else if (clear) begin
      tone_cnt_q <= '0;
      out_q      <= 1'b0;
    end else if (en) begin
      if (tone_cnt_q == half_period - 18'd1) begin
        tone_cnt_q <= '0;
        out_q      <= ~out_q;
      end else begin
        tone_cnt_q <= tone_cnt_q + 18'd1;
      end
    end
  end

  assign out = out_q;

endmodule

// File: rtl/note_tone_player.sv
// Plays the note selected by the key-event stream as a square wave on the
// buzzer, with a minimum note length, a silent gap between notes and an
// optional stuck-note timeout (define NOTE_TIMEOUT_EN to enable it).
// Ports:
//   clk, rst      clock and asynchronous active-high reset
//   key_valid     one-cycle key-press strobe, qualifies key_code
//   key_code      scan code
//   key_released  one-cycle release strobe
//   audio_pwm     square-wave tone, 0 when silent
//   audio_sd      amplifier enable, 1 only while playing
//   note_idx      sounding note 1=DO..7=SI, 0 when silent
//   playing       high while a note sounds
module note_tone_player
  import note_pkg::*;
#(
  parameter int unsigned CLK_HZ          = 100000000,
  parameter int unsigned MIN_PLAY_CYCLES = 10000000,
  parameter int unsigned GAP_CYCLES      = 1000000,
  parameter int unsigned MAX_PLAY_CYCLES = 100000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [7:0] key_code,
  input  logic       key_released,
  output logic       audio_pwm,
  output logic       audio_sd,
  output logic [2:0] note_idx,
  output logic       playing
);

`ifdef NOTE_TIMEOUT_EN
  localparam bit TimeoutEn = 1'b1;
`else
  localparam bit TimeoutEn = 1'b0;
`endif

  localparam logic [17:0] HALF_TAB [8] = '{
    note_half_period(3'd0, CLK_HZ), note_half_period(3'd1, CLK_HZ),
    note_half_period(3'd2, CLK_HZ), note_half_period(3'd3, CLK_HZ),
    note_half_period(3'd4, CLK_HZ), note_half_period(3'd5, CLK_HZ),
    note_half_period(3'd6, CLK_HZ), note_half_period(3'd7, CLK_HZ)
  };

  state_t      state_q;
  logic [2:0]  pend_q;        // pending note, 0 = none
  logic        release_req_q;
  logic [31:0] play_timer_q;
  logic [31:0] gap_cnt_q;
  logic        tone_out;

  logic [2:0]  key_note;
  logic        key_hit;
  logic        min_met;
  logic        timeout_hit;
  logic        gap_done;
  logic [2:0]  pend_gap_d;

  always_comb begin
    key_note    = key_valid ? code_to_note(key_code) : 3'd0;
    key_hit     = (key_note != 3'd0);
    min_met     = (play_timer_q >= MIN_PLAY_CYCLES);
    timeout_hit = TimeoutEn && (play_timer_q == MAX_PLAY_CYCLES - 1);
    gap_done    = (gap_cnt_q == GAP_CYCLES - 1);
    // Pending note as updated by this cycle's events; a press beats a release.
    pend_gap_d  = key_hit ? key_note : (key_released ? 3'd0 : pend_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      pend_q        <= 3'd0;
      release_req_q <= 1'b0;
      play_timer_q  <= '0;
      gap_cnt_q     <= '0;
      note_idx      <= 3'd0;
      playing       <= 1'b0;
      audio_sd      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (key_hit) begin
            state_q       <= StPlay;
            note_idx      <= key_note;
            playing       <= 1'b1;
            audio_sd      <= 1'b1;
            play_timer_q  <= '0;
            release_req_q <= 1'b0;
          end
        end
        StPlay: begin
          if (play_timer_q != '1) play_timer_q <= play_timer_q + 32'd1;
          if (key_hit || ((key_released || release_req_q) && min_met) || timeout_hit) begin
            state_q       <= StGap;
            gap_cnt_q     <= '0;
            note_idx      <= 3'd0;
            playing       <= 1'b0;
            audio_sd      <= 1'b0;
            release_req_q <= 1'b0;
            pend_q        <= key_note;
          end else if (key_released) begin
            release_req_q <= 1'b1;
          end
        end
        StGap: begin
          gap_cnt_q <= gap_cnt_q + 32'd1;
          if (gap_done) begin
            pend_q <= 3'd0;
            if (pend_gap_d != 3'd0) begin
              state_q       <= StPlay;
              note_idx      <= pend_gap_d;
              playing       <= 1'b1;
              audio_sd      <= 1'b1;
              play_timer_q  <= '0;
              release_req_q <= 1'b0;
            end else begin
              state_q <= StIdle;
            end
          end else begin
            pend_q <= pend_gap_d;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Held clear outside PLAY so every note starts at count 0, output low.
  tone_divider u_tone_divider (
    .clk         (clk),
    .rst         (rst),
    .en          (state_q == StPlay),
    .half_period (HALF_TAB[note_idx]),
    .clear       (state_q != StPlay),
    .out         (tone_out)
  );

  // Gating with playing silences the first GAP cycle and reset at once.
  assign audio_pwm = tone_out & playing;

endmodule
